// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle: decoded ID fields and pipeline controls
// in, registered ID_EX fields plus hazard/stall status out.
interface id_ex_stage_if #(
    parameter int DW = 32
);
    // Decoded instruction from the ID stage
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;
    logic [DW-1:0] id_rdata1;
    logic [DW-1:0] id_rdata2;
    logic [DW-1:0] id_imm;
    logic          id_valid;
    logic          id_RegWrite;
    logic          id_MemRead;
    logic          id_MemWrite;
    logic          id_MemtoReg;
    logic          id_ALUSrc;
    logic          id_RegDst;
    logic          id_uses_rt;
    logic [3:0]    id_ALUOp;

    // Pipeline controls
    logic          flush;
    logic          mem_stall;

    // Registered ID/EX contents
    logic [5:0]    ID_EX_opcode;
    logic [4:0]    ID_EX_rs;
    logic [4:0]    ID_EX_rt;
    logic [4:0]    ID_EX_rd;
    logic [DW-1:0] ID_EX_rdata1;
    logic [DW-1:0] ID_EX_rdata2;
    logic [DW-1:0] ID_EX_imm;
    logic          ID_EX_valid;
    logic          ID_EX_RegWrite;
    logic          ID_EX_MemRead;
    logic          ID_EX_MemWrite;
    logic          ID_EX_MemtoReg;
    logic          ID_EX_ALUSrc;
    logic          ID_EX_RegDst;
    logic [3:0]    ID_EX_ALUOp;

    // Upstream write enables and status
    logic          pc_write;
    logic          if_id_write;
    logic [1:0]    state;
    logic [15:0]   bubble_cnt;

    modport master (
        output id_opcode, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_valid, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
               id_ALUSrc, id_RegDst, id_uses_rt, id_ALUOp, flush, mem_stall,
        input  ID_EX_opcode, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_rdata1,
               ID_EX_rdata2, ID_EX_imm, ID_EX_valid, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
               ID_EX_RegDst, ID_EX_ALUOp, pc_write, if_id_write, state,
               bubble_cnt
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_valid, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
               id_ALUSrc, id_RegDst, id_uses_rt, id_ALUOp, flush, mem_stall,
        output ID_EX_opcode, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_rdata1,
               ID_EX_rdata2, ID_EX_imm, ID_EX_valid, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
               ID_EX_RegDst, ID_EX_ALUOp, pc_write, if_id_write, state,
               bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles,
// MEM-stall freeze and a saturating bubble counter.
module id_ex_stage #(
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);
    localparam logic [1:0]  ST_RUN    = 2'b00;
    localparam logic [1:0]  ST_BUBBLE = 2'b01;
    localparam logic [1:0]  ST_FROZEN = 2'b10;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef struct packed {
        logic          valid;
        logic [5:0]    opcode;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [DW-1:0] rdata1;
        logic [DW-1:0] rdata2;
        logic [DW-1:0] imm;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic          reg_dst;
        logic [3:0]    alu_op;
    } id_ex_t;

    // An all-zero entry is a bubble: invalid, no side effects, no operands
    localparam id_ex_t BUBBLE_ENTRY = '0;

    id_ex_t      id_ex_r;
    id_ex_t      id_ex_in_s;
    id_ex_t      id_ex_nxt_s;
    logic [1:0]  state_r;
    logic [1:0]  state_pri_s;
    logic [1:0]  state_nxt_s;
    logic [15:0] bubble_cnt_r;
    logic [15:0] bubble_cnt_nxt_s;
    logic        load_use_s;
    logic        hold_s;
    logic        bubble_s;
    logic        count_s;

    // Gather the decoded ID instruction into one pipeline entry
    always_comb begin
        id_ex_in_s            = BUBBLE_ENTRY;
        id_ex_in_s.valid      = bus.id_valid;
        id_ex_in_s.opcode     = bus.id_opcode;
        id_ex_in_s.rs         = bus.id_rs;
        id_ex_in_s.rt         = bus.id_rt;
        id_ex_in_s.rd         = bus.id_rd;
        id_ex_in_s.rdata1     = bus.id_rdata1;
        id_ex_in_s.rdata2     = bus.id_rdata2;
        id_ex_in_s.imm        = bus.id_imm;
        id_ex_in_s.reg_write  = bus.id_RegWrite;
        id_ex_in_s.mem_read   = bus.id_MemRead;
        id_ex_in_s.mem_write  = bus.id_MemWrite;
        id_ex_in_s.mem_to_reg = bus.id_MemtoReg;
        id_ex_in_s.alu_src    = bus.id_ALUSrc;
        id_ex_in_s.reg_dst    = bus.id_RegDst;
        id_ex_in_s.alu_op     = bus.id_ALUOp;
    end

    // Load in EX whose destination is a source of the instruction in ID;
    // $0 never creates a dependency
    always_comb begin
        load_use_s = id_ex_r.valid && id_ex_r.mem_read &&
                     (id_ex_r.rt != 5'd0) && bus.id_valid &&
                     ((id_ex_r.rt == bus.id_rs) ||
                      (bus.id_uses_rt && (id_ex_r.rt == bus.id_rt)));
    end

    // Priority resolution: mem_stall, then flush, then load-use, then capture
    always_comb begin
        hold_s      = 1'b0;
        bubble_s    = 1'b0;
        count_s     = 1'b0;
        state_pri_s = ST_RUN;
        if (bus.mem_stall) begin
            hold_s      = 1'b1;
            state_pri_s = ST_FROZEN;
        end else if (bus.flush) begin
            bubble_s    = 1'b1;
            count_s     = 1'b1;
            state_pri_s = ST_RUN;
        end else if (load_use_s) begin
            bubble_s    = 1'b1;
            count_s     = 1'b1;
            state_pri_s = ST_BUBBLE;
        end else if (!bus.id_valid) begin
            // Empty ID slot: insert an uncounted bubble
            bubble_s    = 1'b1;
            state_pri_s = ST_RUN;
        end else begin
            state_pri_s = ST_RUN;
        end
    end

    // Next state; the unused encoding returns to RUN on the next edge
    always_comb begin
        case (state_r)
            ST_RUN, ST_BUBBLE, ST_FROZEN: state_nxt_s = state_pri_s;
            default:                      state_nxt_s = ST_RUN;
        endcase
    end

    // Next pipeline entry and saturating bubble count
    always_comb begin
        if (hold_s) begin
            id_ex_nxt_s = id_ex_r;
        end else if (bubble_s) begin
            id_ex_nxt_s = BUBBLE_ENTRY;
        end else begin
            id_ex_nxt_s = id_ex_in_s;
        end
        if (count_s && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_nxt_s = bubble_cnt_r + 16'd1;
        end else begin
            bubble_cnt_nxt_s = bubble_cnt_r;
        end
    end

    // Upstream write enables: frozen on mem_stall, held on a load-use stall
    // unless a flush discards the dependent instruction anyway
    always_comb begin
        bus.pc_write    = !bus.mem_stall && (bus.flush || !load_use_s);
        bus.if_id_write = !bus.mem_stall && (bus.flush || !load_use_s);
    end

    // Pipeline register, FSM state and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_r      <= BUBBLE_ENTRY;
            state_r      <= ST_RUN;
            bubble_cnt_r <= 16'd0;
        end else begin
            id_ex_r      <= id_ex_nxt_s;
            state_r      <= state_nxt_s;
            bubble_cnt_r <= bubble_cnt_nxt_s;
        end
    end

    assign bus.ID_EX_valid    = id_ex_r.valid;
    assign bus.ID_EX_opcode   = id_ex_r.opcode;
    assign bus.ID_EX_rs       = id_ex_r.rs;
    assign bus.ID_EX_rt       = id_ex_r.rt;
    assign bus.ID_EX_rd       = id_ex_r.rd;
    assign bus.ID_EX_rdata1   = id_ex_r.rdata1;
    assign bus.ID_EX_rdata2   = id_ex_r.rdata2;
    assign bus.ID_EX_imm      = id_ex_r.imm;
    assign bus.ID_EX_RegWrite = id_ex_r.reg_write;
    assign bus.ID_EX_MemRead  = id_ex_r.mem_read;
    assign bus.ID_EX_MemWrite = id_ex_r.mem_write;
    assign bus.ID_EX_MemtoReg = id_ex_r.mem_to_reg;
    assign bus.ID_EX_ALUSrc   = id_ex_r.alu_src;
    assign bus.ID_EX_RegDst   = id_ex_r.reg_dst;
    assign bus.ID_EX_ALUOp    = id_ex_r.alu_op;
    assign bus.state          = state_r;
    assign bus.bubble_cnt     = bubble_cnt_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam logic [1:0] RUN = 2'b00, BUB = 2'b01, FRZ = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW)) bus ();
    id_ex_stage #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic          valid;
        logic [5:0]    opcode;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] rdata1, rdata2, imm;
        logic [5:0]    ctl;   // RegWrite MemRead MemWrite MemtoReg ALUSrc RegDst
        logic [3:0]    aluop;
        logic [1:0]    state;
        logic [15:0]   cnt;
    } snap_t;

    snap_t exp_q[$];
    snap_t last_exp;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic snap_t observe();
        snap_t s;
        s.valid  = bus.ID_EX_valid;
        s.opcode = bus.ID_EX_opcode;
        s.rs     = bus.ID_EX_rs;
        s.rt     = bus.ID_EX_rt;
        s.rd     = bus.ID_EX_rd;
        s.rdata1 = bus.ID_EX_rdata1;
        s.rdata2 = bus.ID_EX_rdata2;
        s.imm    = bus.ID_EX_imm;
        s.ctl    = {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                    bus.ID_EX_MemtoReg, bus.ID_EX_ALUSrc, bus.ID_EX_RegDst};
        s.aluop  = bus.ID_EX_ALUOp;
        s.state  = bus.state;
        s.cnt    = bus.bubble_cnt;
        return s;
    endfunction

    // Expected entry when the instruction currently driven in ID is captured
    function automatic snap_t cap_exp(logic [1:0] st, logic [15:0] c);
        snap_t s;
        s.valid  = bus.id_valid;
        s.opcode = bus.id_opcode;
        s.rs     = bus.id_rs;
        s.rt     = bus.id_rt;
        s.rd     = bus.id_rd;
        s.rdata1 = bus.id_rdata1;
        s.rdata2 = bus.id_rdata2;
        s.imm    = bus.id_imm;
        s.ctl    = {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
                    bus.id_MemtoReg, bus.id_ALUSrc, bus.id_RegDst};
        s.aluop  = bus.id_ALUOp;
        s.state  = st;
        s.cnt    = c;
        return s;
    endfunction

    function automatic snap_t bub_exp(logic [1:0] st, logic [15:0] c);
        snap_t s;
        s = '0;
        s.state = st;
        s.cnt   = c;
        return s;
    endfunction

    task automatic compare(input snap_t e, input string tag);
        snap_t o;
        o = observe();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_ctl(input logic pc, input logic ifid, input string tag);
        #1;
        n_assert++;
        assert ({bus.pc_write, bus.if_id_write} === {pc, ifid}) else begin
            n_fail++;
            $error("FAIL %s: observed pc_write/if_id_write %b%b expected %b%b",
                   tag, bus.pc_write, bus.if_id_write, pc, ifid);
        end
    endtask

    task automatic tick(input string tag);
        snap_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            compare(e, tag);
            last_exp = e;
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [5:0] ctl,
                          input logic [3:0] aluop, input logic uses_rt);
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_rdata1   = d1;
        bus.id_rdata2   = d2;
        bus.id_imm      = imm;
        {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
         bus.id_MemtoReg, bus.id_ALUSrc, bus.id_RegDst} = ctl;
        bus.id_ALUOp    = aluop;
        bus.id_uses_rt  = uses_rt;
    endtask

    // lw rt <- mem[rs + imm]
    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 6'h23, rs, rt, 5'd0, 32'h1111_0000, 32'h2222_0000,
               32'd100, 6'b110110, 4'd0, 1'b0);
    endtask

    // R-type add rd <- rs + rt
    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_id(1'b1, 6'h00, rs, rt, rd, 32'hA5A5_0001, 32'h5A5A_0002,
               32'h0000_0000, 6'b100001, 4'd2, 1'b1);
    endtask

    initial begin
        snap_t s;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'd0, 4'd0, 1'b0);
        #2;
        compare(bub_exp(RUN, 16'd0), "reset_state");
        check_ctl(1'b1, 1'b1, "reset_ctl");
        last_exp = bub_exp(RUN, 16'd0);
        #4 rst_n = 1'b1;

        // Load-use on rs: one bubble, then the dependent add is captured
        set_lw(5'd1, 5'd8);
        check_ctl(1'b1, 1'b1, "lw_ctl");
        exp_q.push_back(cap_exp(RUN, 16'd0));
        tick("lw_capture");
        set_add(5'd8, 5'd9, 5'd10);
        check_ctl(1'b0, 1'b0, "lu_rs_ctl");
        exp_q.push_back(bub_exp(BUB, 16'd1));
        tick("lu_rs_bubble");
        check_ctl(1'b1, 1'b1, "after_bubble_ctl");
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("add_capture");

        // rt match without rt use: no stall
        set_lw(5'd2, 5'd8);
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("lw2_capture");
        set_id(1'b1, 6'h08, 5'd9, 5'd8, 5'd0, 32'h0000_0009, 32'h0, 32'h0000_0044,
               6'b100010, 4'd0, 1'b0);
        check_ctl(1'b1, 1'b1, "addi_nostall_ctl");
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("addi_capture");

        // lw to $0 never stalls
        set_lw(5'd0, 5'd0);
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("lw_r0_capture");
        set_add(5'd0, 5'd0, 5'd3);
        check_ctl(1'b1, 1'b1, "r0_nostall_ctl");
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("r0_add_capture");

        // Load-use through rt (sw uses rt)
        set_lw(5'd4, 5'd5);
        exp_q.push_back(cap_exp(RUN, 16'd1));
        tick("lw5_capture");
        set_id(1'b1, 6'h2B, 5'd2, 5'd5, 5'd0, 32'h0000_0200, 32'hDEAD_BEEF, 32'd8,
               6'b001010, 4'd0, 1'b1);
        check_ctl(1'b0, 1'b0, "lu_rt_ctl");
        exp_q.push_back(bub_exp(BUB, 16'd2));
        tick("lu_rt_bubble");
        exp_q.push_back(cap_exp(RUN, 16'd2));
        tick("sw_capture");

        // Invalid ID slot: uncounted bubble, no stall
        set_lw(5'd1, 5'd8);
        exp_q.push_back(cap_exp(RUN, 16'd2));
        tick("lw3_capture");
        set_add(5'd8, 5'd9, 5'd10);
        bus.id_valid = 1'b0;
        check_ctl(1'b1, 1'b1, "idinvalid_ctl");
        exp_q.push_back(bub_exp(RUN, 16'd2));
        tick("idinvalid_bubble");

        // Load-use and flush together: flush wins, one count
        set_lw(5'd1, 5'd8);
        exp_q.push_back(cap_exp(RUN, 16'd2));
        tick("lw4_capture");
        set_add(5'd8, 5'd9, 5'd10);
        bus.flush = 1'b1;
        check_ctl(1'b1, 1'b1, "flush_lu_ctl");
        exp_q.push_back(bub_exp(RUN, 16'd3));
        tick("flush_lu_bubble");
        bus.flush = 1'b0;

        // mem_stall for 3 cycles freezes the held load, then the stall follows
        set_lw(5'd1, 5'd8);
        exp_q.push_back(cap_exp(RUN, 16'd3));
        tick("lw5b_capture");
        set_add(5'd8, 5'd9, 5'd10);
        bus.mem_stall = 1'b1;
        check_ctl(1'b0, 1'b0, "frozen_ctl");
        for (int i = 0; i < 3; i++) begin
            s = last_exp;
            s.state = FRZ;
            exp_q.push_back(s);
            tick("frozen_hold");
        end
        bus.mem_stall = 1'b0;
        check_ctl(1'b0, 1'b0, "unfreeze_lu_ctl");
        exp_q.push_back(bub_exp(BUB, 16'd4));
        tick("unfreeze_bubble");
        exp_q.push_back(cap_exp(RUN, 16'd4));
        tick("unfreeze_add_capture");

        // Saturation: 65537 consecutive flushes
        bus.flush = 1'b1;
        repeat (65536) @(posedge clk);
        exp_q.push_back(bub_exp(RUN, 16'hFFFF));
        tick("cnt_saturate");
        bus.flush = 1'b0;

        // Reset between edges while in BUBBLE
        set_lw(5'd1, 5'd8);
        exp_q.push_back(cap_exp(RUN, 16'hFFFF));
        tick("lw6_capture");
        set_add(5'd8, 5'd9, 5'd10);
        exp_q.push_back(bub_exp(BUB, 16'hFFFF));
        tick("sat_bubble");
        #2 rst_n = 1'b0;
        #1;
        compare(bub_exp(RUN, 16'd0), "async_reset");
        check_ctl(1'b1, 1'b1, "async_reset_ctl");
        #1 rst_n = 1'b1;
        exp_q.push_back(cap_exp(RUN, 16'd0));
        tick("post_reset_capture");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of register-read and immediate fields.
REQ-002 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have inputs id_opcode[5:0], id_rs[4:0], id_rt[4:0], id_rd[4:0], id_rdata1[DW-1:0], id_rdata2[DW-1:0], id_imm[DW-1:0] (decoded ID instruction).
REQ-005 SHALL have 1-bit inputs id_valid, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst, id_uses_rt (ID reads rt as a source: R-type, sw, beq), plus id_ALUOp[3:0].
REQ-006 SHALL have 1-bit inputs flush (branch/jump resolved taken in EX) and mem_stall (MEM stage busy, freeze pipeline).
REQ-007 SHALL have registered outputs ID_EX_* mirroring every REQ-004/005 field except id_uses_rt; ID_EX_opcode, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_RegWrite feed the forwarding unit.
REQ-008 SHALL have combinational outputs pc_write (1), if_id_write (1), plus registered state[1:0] and bubble_cnt[15:0].

Function
REQ-009 SHALL implement FSM states RUN=2'b00, BUBBLE=2'b01, FROZEN=2'b10; 2'b11 unreachable, recovers to RUN next edge.
REQ-010 load_use SHALL be 1 iff ID_EX_valid & ID_EX_MemRead & ID_EX_rt!=0 & (ID_EX_rt==id_rs | (id_uses_rt & ID_EX_rt==id_rt)) & id_valid.
REQ-011 Per-edge priority SHALL be: mem_stall > flush > load_use > capture.
REQ-012 mem_stall=1: all ID_EX_* hold, state->FROZEN, bubble_cnt holds; pc_write=0, if_id_write=0.
REQ-013 flush=1 (mem_stall=0): bubble loaded, state->RUN, bubble_cnt+1; pc_write=1, if_id_write=1; load_use ignored.
REQ-014 load_use=1 (no mem_stall/flush): bubble loaded, state->BUBBLE, bubble_cnt+1; pc_write=0, if_id_write=0 same cycle.
REQ-015 Bubble SHALL set ID_EX_valid and all control bits to 0, ID_EX_ALUOp=0, ID_EX_rs/rt/rd=0, data fields=0, opcode=0.
REQ-016 Capture: all ID_EX_* <= id_* on the edge, state->RUN; pc_write=1, if_id_write=1.
REQ-017 id_valid=0 on capture SHALL load a bubble without incrementing bubble_cnt.
REQ-018 Load-use stall SHALL last exactly one cycle: following cycle ID_EX_MemRead=0, so the held ID instruction is captured on next edge.
REQ-019 Leaving FROZEN SHALL re-evaluate REQ-011 against the held ID_EX contents (a held load still forces its stall).
REQ-020 bubble_cnt SHALL saturate at 16'hFFFF, no wrap.
REQ-021 Latency ID->ID_EX outputs SHALL be one clock; pc_write/if_id_write SHALL be pure combinational from current inputs and ID_EX state.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force all ID_EX_* to 0, state=RUN, bubble_cnt=0.
REQ-023 During reset pc_write=1, if_id_write=1 (ID_EX_valid=0 gives load_use=0, mem_stall still honored).
REQ-024 Release SHALL be synchronous to the next clk edge with no spurious bubble count; reset mid-stall SHALL abandon the stall.

Verification
REQ-025 lw $8 in ID_EX (MemRead=1, rt=8); ID add rs=8 -> pc_write=0, if_id_write=0, next edge ID_EX_valid=0, state=BUBBLE, bubble_cnt=1; following edge add captured, state=RUN.
REQ-026 lw rt=8; ID addi rs=9, rt=8, id_uses_rt=0 -> no stall, addi captured; lw rt=0 with rs=0 -> no stall.
REQ-027 load_use and flush same cycle -> bubble, state=RUN, pc_write=1, bubble_cnt+1 only once.
REQ-028 mem_stall=1 for 3 cycles with lw in ID_EX and dependent ID -> ID_EX unchanged, state=FROZEN, pc_write=0; on release one-cycle load-use bubble follows.
REQ-029 Force 65536 flushes -> bubble_cnt stays 16'hFFFF.
REQ-030 rst_n low mid-BUBBLE between edges -> outputs 0 and state=RUN before next edge; first post-reset edge captures ID normally.
